abc: RTL and testbench
======================

# abc

Position-tracking block: on each consumer request it starts one conversion on each of two 4-bit velocity converters (vx, vy) and adds the signed samples to an internal 8-bit signed position (x, y). It then presents the new position through a soc/eoc handshake. It sits between two ADC-style velocity sources and a downstream consumer that reads the position.

## Interface
Parameters: none. Widths are fixed package constants.
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- vx  in  4  signed X velocity sample; valid while eoc_vx=1 after a conversion
- soc_vx  out  1  start-of-conversion to X converter
- eoc_vx  in  1  end-of-conversion from X converter (1 = idle/done)
- vy  in  4  signed Y velocity sample
- soc_vy  out  1  start-of-conversion to Y converter
- eoc_vy  in  1  end-of-conversion from Y converter
- x  out  8  signed X position, two's complement
- y  out  8  signed Y position, two's complement
- soc_p  in  1  consumer request
- eoc_p  out  1  position ready (1 = idle, x/y valid)

## Operation
- Reset values: soc_vx=0, soc_vy=0, eoc_p=1, x=0, y=0. State is IDLE.
- Reset asserted mid-operation aborts the transaction. The next edge restores the reset values.
- IDLE: eoc_p=1 and x/y are held. When soc_p=1 is sampled, go to START and drive eoc_p=0.
- START: drive soc_vx=1 and soc_vy=1.
  - Each channel independently drops its soc once its eoc is sampled 0. That channel then goes to its wait phase.
- WAIT: for each channel, when eoc is sampled 1 with soc=0, capture vx (or vy) on that edge and mark the channel done.
  - The channels run in parallel and may finish in either order.
- UPDATE (both channels done): compute the 9-bit sign-extended sums x+vx and y+vy.
  - If a sum fits in -128..127, load it. Otherwise keep the old value.
  - X and Y are evaluated independently.
- DONE: wait until soc_p=0 is sampled, then drive eoc_p=1 and return to IDLE.
- soc_p may fall at any time after eoc_p falls, including before the conversions finish.
- x and y change only in UPDATE, while eoc_p=0. They are stable whenever eoc_p=1.

## Timing
- eoc_p falls on the first edge after soc_p=1 is sampled in IDLE. soc_vx and soc_vy rise on that same edge.
- A soc output falls one edge after its eoc is sampled 0.
- The sample is captured on the first edge where eoc=1 is sampled after soc fell.
- UPDATE takes one cycle after the later of the two captures.
- eoc_p rises on the first edge in DONE with soc_p=0. With soc_p already 0, latency is 1 cycle after UPDATE.
- Converter latency is unbounded; the block waits indefinitely.

## Configuration
- Macro ABC_CLAMP_EN.
- Undefined (default): on overflow, the coordinate keeps its previous value.
- Defined: on overflow, the coordinate saturates to +127 or -128.
- All other behaviour is identical in both builds.

## Structure
- Package abc_pkg holds:
  - constants V_W=4 and P_W=8;
  - the state enum IDLE, START, WAIT, UPDATE, DONE;
  - the overflow-check / clamp function.
- Sub-module abc_adc_ctrl, instantiated twice (X, Y). It runs one channel's soc/eoc handshake and owns the sample register and the done flag.
- The top level holds the consumer FSM and the two position registers.

## Test plan
- Reset with eoc_vx=eoc_vy=1, soc_p=0 -> soc_vx=0, soc_vy=0, eoc_p=1, x=0, y=0.
- Request with vx=5, vy=0 from reset -> eoc_p returns to 1 with (x,y)=(5,0).
- Next requests with (vx,vy)=(-7,7), then (4,7) -> (-2,7), then (2,14).
- From x=-127: vx=-1 -> -128; then vx=-5 -> x stays -128. With ABC_CLAMP_EN defined: -128.
- From x=-126: vx=-8 -> x stays -126. From x=-123: vx=-6 -> stays -123, while y updates normally in the same transaction.
- X converter 5 cycles and Y converter 3 cycles slow, soc_p dropped 2 cycles after eoc_p falls -> eoc_p rises only after both samples are captured; x/y unchanged for 1.5 cycles after the eoc_p rise.
- Assert reset mid-conversion -> all outputs return to reset values on the next edge. A fresh request then starts from (0,0).

Source files
------------

// File: rtl/abc_pkg.sv
// abc_pkg: shared constants, FSM state types and the position update
// function for the abc position tracker.
//   V_W        : velocity sample width (signed)
//   P_W        : position width (signed)
//   state_t    : consumer-side FSM states
//   ch_state_t : per-converter handshake states
//   pos_update : adds a velocity to a position with overflow handling.
// Build option: ABC_CLAMP_EN. When it is defined, an overflowing coordinate
// saturates to +127 or -128. When it is undefined, the coordinate keeps its
// previous value.
package abc_pkg;

  localparam int V_W = 4;
  localparam int P_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    UPDATE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_SOC,
    CH_WAIT
  } ch_state_t;

  // The sum is formed one bit wider than the position.
  // It fits in P_W bits exactly when its top two bits agree.
  function automatic logic signed [P_W-1:0] pos_update(
    input logic signed [P_W-1:0] pos,
    input logic signed [V_W-1:0] v
  );
    logic signed [P_W:0] sum;
    sum = {pos[P_W-1], pos} + {{(P_W + 1 - V_W){v[V_W-1]}}, v};
    if (sum[P_W] == sum[P_W-1]) begin
      return sum[P_W-1:0];
    end
`ifdef ABC_CLAMP_EN
    return sum[P_W] ? {1'b1, {(P_W - 1){1'b0}}} : {1'b0, {(P_W - 1){1'b1}}};
`else
    return pos;
`endif
  endfunction

endpackage

// File: rtl/abc_if.sv
// abc_if: bundles the converter handshakes and the consumer handshake of abc.
//   vx/vy         : signed velocity samples from the converters
//   soc_vx/soc_vy : start-of-conversion to the converters
//   eoc_vx/eoc_vy : end-of-conversion from the converters (1 = idle/done)
//   x/y           : signed position presented to the consumer
//   soc_p         : consumer request
//   eoc_p         : position ready (1 = idle, x/y valid)
// The slave modport is the abc side. The master modport is the environment
// side, covering the converters and the consumer.
interface abc_if;
  import abc_pkg::*;

  logic signed [V_W-1:0] vx;
  logic                  soc_vx;
  logic                  eoc_vx;
  logic signed [V_W-1:0] vy;
  logic                  soc_vy;
  logic                  eoc_vy;
  logic signed [P_W-1:0] x;
  logic signed [P_W-1:0] y;
  logic                  soc_p;
  logic                  eoc_p;

  modport slave (
    input  vx, eoc_vx, vy, eoc_vy, soc_p,
    output soc_vx, soc_vy, x, y, eoc_p
  );

  modport master (
    output vx, eoc_vx, vy, eoc_vy, soc_p,
    input  soc_vx, soc_vy, x, y, eoc_p
  );
endinterface

// File: rtl/abc_adc_ctrl.sv
// abc_adc_ctrl: runs the soc/eoc handshake for one velocity converter.
//   clock, reset : system clock, synchronous active-high reset
//   start        : one-cycle pulse that launches a conversion
//   eoc, v       : end-of-conversion and sample from the converter
//   soc          : start-of-conversion to the converter
//   sample, done : captured sample, and a flag that is set until the next start
module abc_adc_ctrl
  import abc_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  eoc,
  input  logic signed [V_W-1:0] v,
  output logic                  soc,
  output logic signed [V_W-1:0] sample,
  output logic                  done
);

  ch_state_t             ch_reg, ch_next;
  logic signed [V_W-1:0] sample_reg;
  logic                  done_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      ch_reg     <= CH_IDLE;
      sample_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      ch_reg <= ch_next;
      if (start) begin
        done_reg <= 1'b0;
      end
      // The converter has finished once eoc returns high after soc was dropped.
      if (ch_reg == CH_WAIT && eoc) begin
        sample_reg <= v;
        done_reg   <= 1'b1;
      end
    end
  end

  always_comb begin
    ch_next = ch_reg;
    case (ch_reg)
      CH_IDLE: if (start) ch_next = CH_SOC;
      CH_SOC:  if (!eoc)  ch_next = CH_WAIT;
      CH_WAIT: if (eoc)   ch_next = CH_IDLE;
      default:            ch_next = CH_IDLE;
    endcase
  end

  assign soc    = (ch_reg == CH_SOC);
  assign sample = sample_reg;
  assign done   = done_reg;

endmodule

// File: rtl/abc.sv
// abc: position tracker. Each consumer request runs one conversion on the X
// converter and one on the Y converter in parallel. The two signed samples
// are added to the 8-bit x/y position, and the result is presented through
// the soc_p/eoc_p handshake.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : abc_if.slave, which carries the converter and consumer signals
// Build option: ABC_CLAMP_EN (see abc_pkg) selects saturation on overflow.
// Without it, an overflowing coordinate keeps its previous value.
module abc
  import abc_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  abc_if.slave  bus
);

  state_t                state_reg, state_next;
  logic                  start;
  logic                  eoc_p_c;
  logic [1:0]            eoc_ch;
  logic [1:0]            soc_ch;
  logic [1:0]            done_ch;
  logic signed [V_W-1:0] v_ch      [2];
  logic signed [V_W-1:0] sample_ch [2];
  logic signed [P_W-1:0] x_reg, y_reg;

  // Index 0 is the X channel and index 1 is the Y channel.
  assign eoc_ch  = {bus.eoc_vy, bus.eoc_vx};
  assign v_ch[0] = bus.vx;
  assign v_ch[1] = bus.vy;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      abc_adc_ctrl u_ctrl (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .eoc    (eoc_ch[gi]),
        .v      (v_ch[gi]),
        .soc    (soc_ch[gi]),
        .sample (sample_ch[gi]),
        .done   (done_ch[gi])
      );
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The START pulse is generated on the IDLE->START transition. As a result,
  // both soc outputs rise on the same edge on which eoc_p falls.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    eoc_p_c    = 1'b0;
    case (state_reg)
      IDLE: begin
        eoc_p_c = 1'b1;
        if (bus.soc_p) begin
          state_next = START;
          start      = 1'b1;
        end
      end
      START:  state_next = WAIT;
      WAIT:   if (&done_ch) state_next = UPDATE;
      UPDATE: state_next = DONE;
      DONE:   if (!bus.soc_p) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The position registers load only while eoc_p is low.
  // Each axis handles overflow on its own.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (state_reg == UPDATE) begin
      x_reg <= pos_update(x_reg, sample_ch[0]);
      y_reg <= pos_update(y_reg, sample_ch[1]);
    end
  end

  assign bus.soc_vx = soc_ch[0];
  assign bus.soc_vy = soc_ch[1];
  assign bus.eoc_p  = eoc_p_c;
  assign bus.x      = x_reg;
  assign bus.y      = y_reg;

endmodule

// File: tb/tb_abc.sv
// tb_abc: directed testbench for abc. Two behavioural converters with
// programmable latency answer the soc requests. The main sequence issues
// consumer requests and checks the position against hand-computed values.
module tb_abc;

`ifdef ABC_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  abc_if bus ();

  abc dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic signed [3:0] next_vx, next_vy;
  int  lat_x = 0, lat_y = 0;
  time ret_x_t = 0, ret_y_t = 0;

  task automatic chk(input string tag, input logic signed [15:0] obs,
                     input logic signed [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // X converter model: it pulls eoc low after seeing soc, then returns the
  // sample lat_x cycles after soc is dropped.
  initial begin
    bus.eoc_vx = 1'b1;
    bus.vx     = '0;
    forever begin
      @(negedge clock);
      if (bus.soc_vx === 1'b1 && bus.eoc_vx === 1'b1) begin
        bus.eoc_vx = 1'b0;
        for (int n = 0; n < 1000 && bus.soc_vx !== 1'b0; n++) @(negedge clock);
        repeat (lat_x) @(negedge clock);
        bus.vx     = next_vx;
        bus.eoc_vx = 1'b1;
        ret_x_t    = $time;
      end
    end
  end

  initial begin
    bus.eoc_vy = 1'b1;
    bus.vy     = '0;
    forever begin
      @(negedge clock);
      if (bus.soc_vy === 1'b1 && bus.eoc_vy === 1'b1) begin
        bus.eoc_vy = 1'b0;
        for (int n = 0; n < 1000 && bus.soc_vy !== 1'b0; n++) @(negedge clock);
        repeat (lat_y) @(negedge clock);
        bus.vy     = next_vy;
        bus.eoc_vy = 1'b1;
        ret_y_t    = $time;
      end
    end
  end

  task automatic do_req(input string tag, input int vxi, input int vyi,
                        input int lx, input int ly, input int drop,
                        input int ex, input int ey);
    int n;
    next_vx = vxi[3:0];
    next_vy = vyi[3:0];
    lat_x   = lx;
    lat_y   = ly;
    @(negedge clock);
    bus.soc_p = 1'b1;
    @(negedge clock);
    chk({tag, ".eoc_p_fall"}, bus.eoc_p, 0);
    chk({tag, ".soc_vx_rise"}, bus.soc_vx, 1);
    chk({tag, ".soc_vy_rise"}, bus.soc_vy, 1);
    repeat (drop) @(negedge clock);
    bus.soc_p = 1'b0;
    n = 0;
    while (bus.eoc_p !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({tag, ".eoc_p_rise_in_time"}, (n < 200), 1);
    // eoc_p may rise only after both samples have been captured and then used.
    chk({tag, ".after_capture"},
        (($time - ret_x_t) >= 20) && (($time - ret_y_t) >= 20), 1);
    chk({tag, ".x"}, bus.x, ex);
    chk({tag, ".y"}, bus.y, ey);
    chk({tag, ".soc_vx_idle"}, bus.soc_vx, 0);
    @(negedge clock);
    chk({tag, ".x_stable"}, bus.x, ex);
    chk({tag, ".y_stable"}, bus.y, ey);
    chk({tag, ".eoc_p_held"}, bus.eoc_p, 1);
    $display("req %s: v=(%0d,%0d) pos=(%0d,%0d) expect=(%0d,%0d)",
             tag, vxi, vyi, bus.x, bus.y, ex, ey);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("reset.x", bus.x, 0);
  endtask

  // Brings x to -120 and y to 0 through fifteen steps of -8.
  task automatic ramp_m120();
    pulse_reset();
    for (int i = 1; i <= 15; i++) begin
      do_req("ramp", -8, 0, 0, 0, 0, -8 * i, 0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.soc_p = 1'b0;
    next_vx   = '0;
    next_vy   = '0;
    repeat (3) @(negedge clock);
    chk("rst.soc_vx", bus.soc_vx, 0);
    chk("rst.soc_vy", bus.soc_vy, 0);
    chk("rst.eoc_p", bus.eoc_p, 1);
    chk("rst.x", bus.x, 0);
    chk("rst.y", bus.y, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle.eoc_p", bus.eoc_p, 1);

    do_req("r1", 5, 0, 0, 0, 0, 5, 0);
    do_req("r2", -7, 7, 1, 0, 0, -2, 7);
    do_req("r3", 4, 7, 0, 2, 0, 2, 14);
    // X is slow by 5 cycles and Y by 3. soc_p falls 2 cycles after eoc_p.
    do_req("slow", 1, 1, 5, 3, 2, 3, 15);

    // Reset in the middle of a conversion.
    next_vx = 4'sd2;
    next_vy = 4'sd2;
    lat_x   = 6;
    lat_y   = 6;
    @(negedge clock);
    bus.soc_p = 1'b1;
    repeat (3) @(negedge clock);
    chk("midrst.busy", bus.eoc_p, 0);
    reset     = 1'b1;
    bus.soc_p = 1'b0;
    @(negedge clock);
    chk("midrst.soc_vx", bus.soc_vx, 0);
    chk("midrst.soc_vy", bus.soc_vy, 0);
    chk("midrst.eoc_p", bus.eoc_p, 1);
    chk("midrst.x", bus.x, 0);
    chk("midrst.y", bus.y, 0);
    reset = 1'b0;
    begin
      int n;
      n = 0;
      while ((bus.eoc_vx !== 1'b1 || bus.eoc_vy !== 1'b1) && n < 100) begin
        @(negedge clock);
        n++;
      end
      chk("midrst.conv_idle", (n < 100), 1);
    end
    do_req("fresh", 3, -2, 0, 0, 0, 3, -2);

    // Negative boundary for x.
    ramp_m120();
    do_req("to_m127", -7, 0, 0, 0, 0, -127, 0);
    do_req("to_m128", -1, 0, 0, 0, 0, -128, 0);
    do_req("ovf_m128", -5, 0, 0, 0, 0, -128, 0);

    ramp_m120();
    do_req("to_m126", -6, 0, 0, 0, 0, -126, 0);
    do_req("ovf_m126", -8, 0, 0, 0, 0, CLAMP ? -128 : -126, 0);

    ramp_m120();
    do_req("to_m123", -3, 0, 0, 0, 0, -123, 0);
    do_req("ovf_m123_y", -6, 3, 0, 0, 0, CLAMP ? -128 : -123, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
